// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux block: the mode encoding and
// the pointer wrap rule used by the round-robin scan.
package scan_mux_pkg;

    typedef enum logic {MODE_FIXED, MODE_SCAN} mode_e;

    function automatic int unsigned next_ptr(int unsigned ptr, int unsigned channels);
        return (ptr == channels - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/scan_mux_ptr.sv
// Channel pointer for scan_mux: software select loads, round-robin advance
// with idle skip, and the one-cycle error pulse for out-of-range selects.
module scan_mux_ptr
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             sel_load_i,
    input  logic             accept_i,
    input  logic             cur_valid_i,
    output logic [SEL_W-1:0] ptr_o,
    output logic             sel_err_o
);

    localparam logic [SEL_W:0] CH_COUNT = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ok;

    assign sel_ok = ({1'b0, sel_i} < CH_COUNT);

    // A load always wins; a rejected load freezes the pointer for that cycle.
    always_comb begin
        ptr_d     = ptr_q;
        sel_err_d = 1'b0;
        if (sel_load_i) begin
            if (sel_ok) begin
                ptr_d = sel_i;
            end else begin
                sel_err_d = 1'b1;
            end
        end else if (mode_e'(mode_i) == MODE_SCAN && (accept_i || !cur_valid_i)) begin
            ptr_d = SEL_W'(next_ptr(32'(ptr_q), 32'(CHANNELS)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign ptr_o     = ptr_q;
    assign sel_err_o = sel_err_q;

endmodule

// File: rtl/scan_mux.sv
// N-channel, W-bit registered multiplexer with a valid/ready output stage;
// channel choice comes from scan_mux_ptr (fixed select or round-robin scan).
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    logic [SEL_W-1:0] ptr;
    logic             can_load;
    logic             cur_valid;
    logic             accept;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_chan_q;
    logic             out_valid_q;

    assign can_load  = !out_valid_q || out_ready;
    assign cur_valid = in_valid[ptr];
    assign accept    = cur_valid && can_load;

    always_comb begin
        in_ready = '0;
        if (can_load) begin
            in_ready[ptr] = 1'b1;
        end
    end

    scan_mux_ptr #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode),
        .sel_i       (sel),
        .sel_load_i  (sel_load),
        .accept_i    (accept),
        .cur_valid_i (cur_valid),
        .ptr_o       (ptr),
        .sel_err_o   (sel_err)
    );

    // Accept takes precedence over drain so back-to-back transfers keep valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_data_q  <= in_data[ptr*WIDTH +: WIDTH];
            out_chan_q  <= ptr;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage. Supports a fixed mode (software-loaded select) and a scan mode (round-robin pointer that skips idle channels). Sits between gate-level input sources and downstream consumers in the circuit examples. It generalises the fixed 4:1, 1-bit select mux to any width and channel count, and adds pipelining and flow control.

## Interface
- `WIDTH`, default 1: data bits per channel.
- `CHANNELS`, default 4: number of input channels, ≥2; need not be a power of two.
- `SEL_W`, default `$clog2(CHANNELS)`: select/pointer width. Derived; never overridden.

- `clk` input, 1: single clock; all state updates on rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `mode` input, 1: 0 = FIXED, 1 = SCAN.
- `sel` input, SEL_W: channel index, used only with `sel_load`.
- `sel_load` input, 1: load `sel` into the pointer.
- `in_data` input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` input, CHANNELS: per-channel valid.
- `in_ready` output, CHANNELS: per-channel ready; one-hot or zero.
- `out_data` output, WIDTH: registered data.
- `out_chan` output, SEL_W: channel index that produced `out_data`.
- `out_valid` output, 1: output register holds data.
- `out_ready` input, 1: consumer accepts.
- `sel_err` output, 1: single-cycle pulse, asserted when `sel_load` carries `sel` ≥ CHANNELS.

## Operation
- Pointer `ptr` (SEL_W) selects the current channel.
- `can_load = !out_valid || out_ready`.
- `in_ready[ptr] = can_load`; every other bit of `in_ready` is 0. `in_ready` is combinational from `ptr`, `out_valid` and `out_ready`.
- Accept happens when `in_valid[ptr] && in_ready[ptr]`. On accept:
  - `out_data <= in_data[ptr]`, `out_chan <= ptr`, `out_valid <= 1`.
- Drain happens when `out_valid && out_ready` and there is no accept in the same cycle. On drain, `out_valid <= 0`.
- FIXED mode: `ptr` changes only on a valid `sel_load`.
- SCAN mode: `ptr` advances by one each cycle when either:
  - an accept occurs, or
  - `in_valid[ptr] == 0` (idle skip, one channel per cycle).
- SCAN mode: `ptr` holds while `in_valid[ptr]` is asserted and the output is stalled.
- Wrap: `ptr == CHANNELS-1` advances to 0. Pointer values ≥ CHANNELS are never produced.
- `sel_load` with `sel < CHANNELS`: `ptr <= sel` next cycle, in either mode. This has priority over a scan advance in the same cycle. An accept in that cycle still uses the old `ptr`.
- `sel_load` with `sel ≥ CHANNELS`: `ptr` unchanged; `sel_err` = 1 for the next cycle only.
- A `mode` change takes effect on the next edge. `ptr` is kept across the change.
- Reset, asserted at any time including mid-transfer:
  - `ptr = 0`, `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `sel_err = 0`.
  - `in_ready` then evaluates to one-hot bit 0.
  - Any pending output data is discarded.

## Timing
- Latency: accept at edge N gives `out_valid`/`out_data` visible after edge N.
- Throughput: one transfer per cycle when `out_ready` is held at 1.
- Back-to-back: drain and accept in the same cycle keep `out_valid = 1` with the new data.
- `out_data`/`out_chan` stay stable while `out_valid && !out_ready`.
- SCAN worst case to reach a valid channel: CHANNELS-1 cycles of idle skip.
- Reset deassertion: first accept is possible at the first edge after `rst` falls.

## Structure
- Package `scan_mux_pkg`:
  - `typedef enum logic {MODE_FIXED, MODE_SCAN} mode_e`.
  - Function `next_ptr(ptr, channels)` implementing the wrap rule.
- Sub-module `scan_mux_ptr`: owns `ptr`, the `sel_load` priority, the scan-advance logic and `sel_err`.
- Top level: output register, `in_ready` decode, data slice.

## Test plan
- Reset/fixed, CHANNELS=4, WIDTH=8: `sel_load` with `sel=2`, `in_data` ch2=0xA5 with `in_valid[2]=1`, `out_ready=1` → `out_data=0xA5`, `out_chan=2` one cycle later; `in_ready=4'b0100`.
- Backpressure: `out_ready=0` with ch2 valid → one accept, then `in_ready=0`; `out_data` stays 0xA5 until `out_ready=1`; then the next word is accepted in the same cycle.
- Scan wrap, CHANNELS=3: all valid, data 0x10/0x11/0x12, `out_ready=1` → `out_chan` sequence 0,1,2,0,1; one output per cycle.
- Idle skip: SCAN mode with only ch3 valid of 4 → `ptr` steps 0→1→2→3, first `out_valid` 4 cycles after reset release.
- Bad select, CHANNELS=3: `sel_load`, `sel=3` → `sel_err` pulses 1 cycle, `ptr` unchanged; `sel_load` colliding with a scan accept → `ptr = sel` next cycle.
- Mid-transfer reset: assert `rst` while `out_valid=1`, `out_ready=0` → `out_valid=0`, `out_data=0`, `ptr=0` immediately, without waiting for a clock edge.
